// File: rtl/block_memory_model_pkg.sv
// Shared constants, state encoding and init pattern for the block memory model and cache.
package block_memory_model_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_BLOCK_SIZE    = 128;
  localparam int unsigned DEF_OFFSET_WIDTH  = 2;
  localparam int unsigned DEF_LATENCY       = 4;
  localparam int unsigned NUM_BLOCKS        = 1 << (DEF_ADDRESS_WIDTH - DEF_OFFSET_WIDTH);
  localparam int unsigned CNT_WIDTH         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } mem_state_e;

  // Power-on content: word w of block b holds its own word address.
  function automatic logic [31:0] init_word(input int unsigned blk, input int unsigned word,
                                            input int unsigned offset_width);
    return 32'((blk << offset_width) + word);
  endfunction

endpackage

// File: rtl/block_memory_model_mem_block_array.sv
// Single-port block storage with registered read data and address-pattern reset init.
module block_memory_model_mem_block_array
  import block_memory_model_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH  = DEF_ADDRESS_WIDTH - DEF_OFFSET_WIDTH,
  parameter int unsigned BLOCK_SIZE   = DEF_BLOCK_SIZE,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic                   re,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic [BLOCK_SIZE-1:0]  wdata,
  output logic [BLOCK_SIZE-1:0]  rdata
);

  localparam int unsigned DEPTH = 1 << INDEX_WIDTH;
  localparam int unsigned WORDS = BLOCK_SIZE / DATA_WIDTH;

  logic [BLOCK_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < DEPTH; b++) begin
        for (int unsigned w = 0; w < WORDS; w++) begin
          mem[INDEX_WIDTH'(b)][w*DATA_WIDTH +: DATA_WIDTH] <=
            DATA_WIDTH'(init_word(b, w, OFFSET_WIDTH));
        end
      end
      rdata <= '0;
    end else begin
      if (we) mem[index] <= wdata;
      // rdata only moves on a read so it holds across writes
      if (re) rdata <= mem[index];
    end
  end

endmodule

// File: rtl/block_memory_model.sv
// Fixed-latency block memory back end: accepts one block read/write, answers with a mem_valid pulse.
module block_memory_model
  import block_memory_model_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned BLOCK_SIZE    = DEF_BLOCK_SIZE,
  parameter int unsigned OFFSET_WIDTH  = DEF_OFFSET_WIDTH,
  parameter int unsigned LATENCY       = DEF_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cache_req,
  input  logic                     cache_write,
  input  logic [ADDRESS_WIDTH-1:0] cache_addr,
  input  logic [BLOCK_SIZE-1:0]    cache_wdata,
  output logic                     mem_valid,
  output logic [BLOCK_SIZE-1:0]    mem_data,
  output logic                     mem_busy
);

  localparam int unsigned INDEX_WIDTH = ADDRESS_WIDTH - OFFSET_WIDTH;

  mem_state_e             state;
  mem_state_e             next_state;
  logic [CNT_WIDTH-1:0]   count;
  logic                   cap_write;
  logic [INDEX_WIDTH-1:0] cap_index;
  logic [BLOCK_SIZE-1:0]  cap_wdata;

  logic                   accept_c;
  logic                   valid_c;
  logic                   busy_c;
  logic                   arr_we_c;
  logic                   arr_re_c;
  logic                   sel_write_c;
  logic [INDEX_WIDTH-1:0] sel_index_c;
  logic [BLOCK_SIZE-1:0]  sel_wdata_c;

  logic [OFFSET_WIDTH-1:0] addr_offset_unused;
  assign addr_offset_unused = cache_addr[OFFSET_WIDTH-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cache_req) next_state = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (count == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output/array-control decode; with LATENCY=1 the response edge is the acceptance edge,
  // so the live inputs are steered to the array while IDLE.
  always_comb begin
    accept_c    = 1'b0;
    sel_write_c = cap_write;
    sel_index_c = cap_index;
    sel_wdata_c = cap_wdata;
    if (state == IDLE) begin
      accept_c    = cache_req;
      sel_write_c = cache_write;
      sel_index_c = cache_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
      sel_wdata_c = cache_wdata;
    end
    valid_c  = (next_state == RESP);
    busy_c   = (next_state != IDLE);
    arr_we_c = valid_c && sel_write_c;
    arr_re_c = valid_c && !sel_write_c;
  end

  // Registered outputs, latency counter and request capture
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_busy  <= 1'b0;
      count     <= '0;
      cap_write <= 1'b0;
      cap_index <= '0;
      cap_wdata <= '0;
    end else begin
      mem_valid <= valid_c;
      mem_busy  <= busy_c;
      if (accept_c) begin
        count     <= CNT_WIDTH'(LATENCY - 1);
        cap_write <= cache_write;
        cap_index <= cache_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
        cap_wdata <= cache_wdata;
      end else if (state == BUSY && count != '0) begin
        count <= count - CNT_WIDTH'(1);
      end
    end
  end

  block_memory_model_mem_block_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .BLOCK_SIZE  (BLOCK_SIZE),
    .DATA_WIDTH  (DATA_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH)
  ) u_mem_block_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we_c),
    .re   (arr_re_c),
    .index(sel_index_c),
    .wdata(sel_wdata_c),
    .rdata(mem_data)
  );

endmodule

// File: tb/tb_block_memory_model.sv
// Directed bench for block_memory_model at LATENCY=4 and LATENCY=1.
module tb_block_memory_model;

  localparam int unsigned BW = 128;

  localparam logic [BW-1:0] B14 = {32'h17, 32'h16, 32'h15, 32'h14};
  localparam logic [BW-1:0] B80 = {32'h83, 32'h82, 32'h81, 32'h80};
  localparam logic [BW-1:0] B08 = {32'h0B, 32'h0A, 32'h09, 32'h08};
  localparam logic [BW-1:0] B34 = {32'h37, 32'h36, 32'h35, 32'h34};
  localparam logic [BW-1:0] B04 = {32'h07, 32'h06, 32'h05, 32'h04};
  localparam logic [BW-1:0] WD  = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
  localparam logic [BW-1:0] WB  = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
  localparam logic [BW-1:0] WR  = {4{32'hFFFF_FFFF}};
  localparam logic [BW-1:0] W30 = {32'h3030_3333, 32'h3030_2222, 32'h3030_1111, 32'h3030_0000};
  localparam logic [BW-1:0] WE  = {32'hEEEE_0004, 32'hEEEE_0003, 32'hEEEE_0002, 32'hEEEE_0001};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst4, req4, wr4, valid4, busy4;
  logic [7:0]    addr4;
  logic [BW-1:0] wdata4, data4;
  logic          rst1, req1, wr1, valid1, busy1;
  logic [7:0]    addr1;
  logic [BW-1:0] wdata1, data1;

  int n_checks = 0;
  int n_errors = 0;

  block_memory_model #(.LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst4), .cache_req(req4), .cache_write(wr4), .cache_addr(addr4),
    .cache_wdata(wdata4), .mem_valid(valid4), .mem_data(data4), .mem_busy(busy4)
  );

  block_memory_model #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst1), .cache_req(req1), .cache_write(wr1), .cache_addr(addr1),
    .cache_wdata(wdata1), .mem_valid(valid1), .mem_data(data1), .mem_busy(busy1)
  );

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One LATENCY=4 transaction; optionally scrambles the inputs while BUSY.
  task automatic txn4(input string tag, input logic wr, input logic [7:0] addr,
                      input logic [BW-1:0] wdata, input logic [BW-1:0] exp_data,
                      input bit toggle);
    req4 = 1'b1; wr4 = wr; addr4 = addr; wdata4 = wdata;
    tick();
    check({tag, " busy e0"}, BW'(busy4), BW'(1'b1));
    check({tag, " valid e0"}, BW'(valid4), BW'(1'b0));
    for (int k = 1; k <= 4; k++) begin
      if (toggle) begin
        wr4 = ~wr; addr4 = addr + 8'(4 * k); wdata4 = ~wdata;
      end
      tick();
      check({tag, " valid"}, BW'(valid4), BW'(k == 4));
      check({tag, " busy"}, BW'(busy4), BW'(1'b1));
    end
    check({tag, " data"}, data4, exp_data);
    req4 = 1'b0;
    tick();
    check({tag, " valid after"}, BW'(valid4), BW'(1'b0));
    check({tag, " busy after"}, BW'(busy4), BW'(1'b0));
  endtask

  initial begin
    int first;
    int second;
    rst4 = 1'b1; req4 = 1'b0; wr4 = 1'b0; addr4 = '0; wdata4 = '0;
    rst1 = 1'b1; req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    tick();
    rst4 = 1'b0; rst1 = 1'b0;
    check("rst valid4", BW'(valid4), BW'(1'b0));
    check("rst busy4", BW'(busy4), BW'(1'b0));
    check("rst data4", data4, '0);
    check("rst valid1", BW'(valid1), BW'(1'b0));
    check("rst busy1", BW'(busy1), BW'(1'b0));
    check("rst data1", data1, '0);

    txn4("rd14", 1'b0, 8'h14, '0, B14, 1'b0);
    txn4("wr20", 1'b1, 8'h20, WD, B14, 1'b0);
    txn4("rd20", 1'b0, 8'h20, '0, WD, 1'b0);

    // Writeback then refill with cache_req held high, switched once mem_valid is seen
    first = -1; second = -1;
    req4 = 1'b1; wr4 = 1'b1; addr4 = 8'h40; wdata4 = WB;
    tick();
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (valid4) begin
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
      if (e == 5) begin
        wr4 = 1'b0; addr4 = 8'h80;
      end
      if (second > 0 && e == second) req4 = 1'b0;
    end
    check("wbrf first pulse", BW'(first), BW'(4));
    check("wbrf second pulse", BW'(second), BW'(10));
    check("wbrf refill data", data4, B80);
    txn4("rd40", 1'b0, 8'h40, '0, WB, 1'b0);

    // Reset at edge 2 of a write drops it
    req4 = 1'b1; wr4 = 1'b1; addr4 = 8'h08; wdata4 = WR;
    tick();
    tick();
    rst4 = 1'b1; req4 = 1'b0;
    tick();
    rst4 = 1'b0;
    check("rstmid busy", BW'(busy4), BW'(1'b0));
    check("rstmid data", data4, '0);
    for (int e = 0; e < 4; e++) begin
      check("rstmid no valid", BW'(valid4), BW'(1'b0));
      tick();
    end
    txn4("rd08", 1'b0, 8'h08, '0, B08, 1'b0);

    txn4("wr30tog", 1'b1, 8'h30, W30, B08, 1'b1);
    txn4("rd30", 1'b0, 8'h30, '0, W30, 1'b0);
    txn4("rd34", 1'b0, 8'h34, '0, B34, 1'b0);

    // LATENCY=1: held request is served twice, two edges apart
    req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h04;
    tick();
    check("l1 valid e0", BW'(valid1), BW'(1'b1));
    check("l1 busy e0", BW'(busy1), BW'(1'b1));
    check("l1 data e0", data1, B04);
    tick();
    check("l1 valid e1", BW'(valid1), BW'(1'b0));
    check("l1 busy e1", BW'(busy1), BW'(1'b0));
    tick();
    check("l1 valid e2", BW'(valid1), BW'(1'b1));
    check("l1 busy e2", BW'(busy1), BW'(1'b1));
    req1 = 1'b0;
    tick();
    check("l1 valid e3", BW'(valid1), BW'(1'b0));
    check("l1 busy e3", BW'(busy1), BW'(1'b0));
    tick();
    check("l1 valid e4", BW'(valid1), BW'(1'b0));

    req1 = 1'b1; wr1 = 1'b1; addr1 = 8'h10; wdata1 = WE;
    tick();
    check("l1 wr valid", BW'(valid1), BW'(1'b1));
    check("l1 wr data held", data1, B04);
    req1 = 1'b0;
    tick();
    check("l1 wr valid after", BW'(valid1), BW'(1'b0));
    req1 = 1'b1; wr1 = 1'b0; wdata1 = '0;
    tick();
    check("l1 rd valid", BW'(valid1), BW'(1'b1));
    check("l1 rd data", data1, WE);
    req1 = 1'b0;
    tick();
    check("l1 rd valid after", BW'(valid1), BW'(1'b0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
